// File: rtl/m_fifo_wm.sv
// m_fifo_wm: synchronous show-ahead FIFO with programmable watermarks, flush and peak-occupancy tracking.
// Optional sticky overflow/underflow flags are built when M_FIFO_WM_ERR_EN is defined.
module m_fifo_wm #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 9,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int unsigned     AW        = $clog2(DEPTH),
  localparam int unsigned     CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] data_in,
  input  logic [CW-1:0]    af_thresh,
  input  logic [CW-1:0]    ae_thresh,
  input  logic             err_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    max_count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [CW-1:0]    count_q, countNs;
  logic [CW-1:0]    maxCount_q, maxCount_d;
  logic             empty_q, full_q, almostFull_q, almostEmpty_q;
  logic             wr, rd;

  // Effective operations; pointers wrap modulo DEPTH, which need not be a power of two.
  always_comb begin
    wr      = push & (~full_q | pop);
    rd      = pop & ~empty_q;
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    countNs = count_q;
    if (flush) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      countNs = '0;
    end else begin
      if (rd) rdPtr_d = (rdPtr_q == LAST_PTR) ? '0 : rdPtr_q + AW'(1);
      if (wr) wrPtr_d = (wrPtr_q == LAST_PTR) ? '0 : wrPtr_q + AW'(1);
      if (wr && !rd)      countNs = count_q + CW'(1);
      else if (rd && !wr) countNs = count_q - CW'(1);
    end
  end

  always_comb begin
    maxCount_d = maxCount_q;
    if (err_clr)                     maxCount_d = countNs;
    else if (countNs > maxCount_q)   maxCount_d = countNs;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VAL;
    end else if (!flush && wr) begin
      mem_q[wrPtr_q] <= data_in;
    end
  end

  // Flush restores the reset flag values but leaves max_count and storage alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr_q       <= '0;
      wrPtr_q       <= '0;
      count_q       <= '0;
      maxCount_q    <= '0;
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
      almostEmpty_q <= 1'b1;
      almostFull_q  <= 1'b0;
    end else begin
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      count_q    <= countNs;
      maxCount_q <= maxCount_d;
      if (flush) begin
        empty_q       <= 1'b1;
        full_q        <= 1'b0;
        almostEmpty_q <= 1'b1;
        almostFull_q  <= 1'b0;
      end else begin
        empty_q       <= (countNs == '0);
        full_q        <= (countNs == DEPTH_C);
        almostEmpty_q <= (countNs <= ae_thresh);
        almostFull_q  <= (countNs >= af_thresh);
      end
    end
  end

  assign data_out     = mem_q[rdPtr_q];
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_full  = almostFull_q;
  assign almost_empty = almostEmpty_q;
  assign count        = count_q;
  assign max_count    = maxCount_q;

`ifdef M_FIFO_WM_ERR_EN
  logic overflow_q, underflow_q;
  logic ovfSet, unfSet;

  assign ovfSet = push & full_q & ~pop & ~flush;
  assign unfSet = pop & empty_q & ~flush;

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= ovfSet | (overflow_q & ~err_clr);
      underflow_q <= unfSet | (underflow_q & ~err_clr);
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && ovfSet) $info("m_fifo_wm: push dropped while full");
    if (!rst && unfSet) $info("m_fifo_wm: pop dropped while empty");
  end
`endif
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
